// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: read-side FSM encoding and width helpers.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Water levels carry one extra bit so a completely full FIFO is representable.
  function automatic int lvl_w(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delays the FIFO read enable and its last-word tag by the FIFO read latency.
module rd_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_last,
  output logic o_vld,
  output logic o_last
);

  logic [LAT-1:0] r_vld_sr;
  logic [LAT-1:0] r_last_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
    end else begin
      r_vld_sr[0]  <= i_vld;
      r_last_sr[0] <= i_last;
      for (int i = 1; i < LAT; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end
    end
  end

  assign o_vld  = r_vld_sr[LAT-1];
  assign o_last = r_last_sr[LAT-1];

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// Read-domain burst scheduler: picks full or partial (timeout/flush) bursts, negotiates
// them with the consumer via req/ack, then streams exactly burst_len words under dst_ready.
module fifo_burst_rd_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int RD_DEPTH_WIDTH = 9,
  parameter int BURST_LEN      = 64,
  parameter int TIMEOUT_CYC    = 1024,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  input  logic                      rempty,
  output logic                      fifo_r_en,
  output logic                      burst_req,
  output logic [RD_DEPTH_WIDTH:0]   burst_len,
  input  logic                      burst_ack,
  input  logic                      dst_ready,
  output logic                      data_valid,
  output logic                      burst_last,
  output logic                      burst_done,
  output logic                      busy
);

  localparam int LVL_W  = lvl_w(RD_DEPTH_WIDTH);
  localparam int TO_W   = (clog2(TIMEOUT_CYC + 1) < 1) ? 1 : clog2(TIMEOUT_CYC + 1);
  localparam int DR_W   = (clog2(RD_LATENCY + 1) < 1) ? 1 : clog2(RD_LATENCY + 1);
  localparam logic [LVL_W-1:0] BURST_LEN_L = LVL_W'(BURST_LEN);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_FIRE     = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [DR_W-1:0]  DR_END      = DR_W'(RD_LATENCY);

  state_t           r_state, w_state_nxt;
  logic [LVL_W-1:0] r_burst_len, w_burst_len_nxt;
  logic [LVL_W-1:0] r_rd_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [DR_W-1:0]  r_drain_cnt;
  logic             r_flush_pend;
  logic             w_idle_eval, w_lvl_nz, w_full, w_timeout, w_launch;
  logic             w_rd_ok, w_last_rd;

  assign w_idle_eval = (r_state == ST_IDLE) && enable;
  assign w_lvl_nz    = (rd_water_level != '0);
  assign w_full      = (rd_water_level >= BURST_LEN_L);
  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_to_cnt == TO_FIRE);
  // A flush arriving this cycle counts immediately, not only once it has been latched.
  assign w_launch    = w_idle_eval &&
                       (w_full || (w_lvl_nz && (r_flush_pend || flush || w_timeout)));

  assign w_rd_ok   = (r_state == ST_READ) && dst_ready && !rempty && (r_rd_cnt < r_burst_len);
  assign w_last_rd = w_rd_ok && (r_rd_cnt == r_burst_len - 1'b1);

  always_comb begin
    w_state_nxt     = r_state;
    w_burst_len_nxt = r_burst_len;
    case (r_state)
      ST_IDLE: if (w_launch) begin
        w_state_nxt     = ST_REQ;
        w_burst_len_nxt = w_full ? BURST_LEN_L : rd_water_level;
      end
      ST_REQ:   if (burst_ack) w_state_nxt = ST_READ;
      ST_READ:  if (w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain_cnt == DR_END) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_burst_len <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_len <= w_burst_len_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt     <= '0;
      r_to_cnt     <= '0;
      r_drain_cnt  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_launch)     r_rd_cnt <= '0;
      else if (w_rd_ok) r_rd_cnt <= r_rd_cnt + 1'b1;

      if (w_idle_eval && w_lvl_nz && !w_full && !w_launch) begin
        if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;

      // An empty FIFO at decision time makes a pending flush meaningless, so drop it.
      if (w_idle_eval && (w_launch || !w_lvl_nz)) r_flush_pend <= 1'b0;
      else if (flush)                             r_flush_pend <= 1'b1;
    end
  end

  rd_lat_pipe #(.LAT(RD_LATENCY)) u_lat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_rd_ok),
    .i_last (w_last_rd),
    .o_vld  (data_valid),
    .o_last (burst_last)
  );

  assign fifo_r_en  = w_rd_ok;
  assign burst_req  = (r_state == ST_REQ);
  assign burst_len  = r_burst_len;
  assign burst_done = (r_state == ST_DRAIN) && (r_drain_cnt == DR_END);
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: cycle table for small bursts, plus burst-level sequences.
module tb_fifo_burst_rd_ctrl;

  localparam int DW = 9;
  localparam int LW = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, flush = 1'b0, rempty = 1'b0;
  logic          burst_ack = 1'b0, dst_ready = 1'b0;
  logic [LW-1:0] level = '0;
  logic          fifo_r_en, burst_req, data_valid, burst_last, burst_done, busy;
  logic [LW-1:0] burst_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_burst_rd_ctrl #(
    .RD_DEPTH_WIDTH(DW), .BURST_LEN(64), .TIMEOUT_CYC(1024), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .rd_water_level(level), .rempty(rempty), .fifo_r_en(fifo_r_en),
    .burst_req(burst_req), .burst_len(burst_len), .burst_ack(burst_ack),
    .dst_ready(dst_ready), .data_valid(data_valid), .burst_last(burst_last),
    .burst_done(burst_done), .busy(busy)
  );

  typedef struct {
    bit       en, fl, ack, rdy, emp;
    int       lvl;
    bit [5:0] exp_o;   // {r_en, req, valid, last, done, busy}
    int       exp_len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit fl, bit ack, bit rdy, bit emp, int lvl,
                              bit [5:0] exp_o, int exp_len);
    vec_t v;
    v.en = en; v.fl = fl; v.ack = ack; v.rdy = rdy; v.emp = emp;
    v.lvl = lvl; v.exp_o = exp_o; v.exp_len = exp_len;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, acks it two cycles later and streams the burst to completion.
  // Called and returns in the drive phase / sample phase respectively.
  task automatic run_burst(input int exp_len, input int mode, input int abort_at,
                           input bit drop_en, output int wait_cyc);
    int  rcnt = 0, vcnt = 0, lastcnt = 0, lastpos = -1, lastcyc = -10, donecyc = -1;
    int  viol = 0, stall_left = 0;
    bit  stalled = 0, prev_ren = 0;
    wait_cyc = -1;
    for (int c = 0; c < 2000; c++) begin
      #4;
      if (burst_req) begin wait_cyc = c; break; end
      next_cyc();
    end
    if (wait_cyc < 0) begin
      chk("req_wait_expired", 0, 1);
      return;
    end
    chk("burst_len", burst_len, exp_len);
    next_cyc();
    #4;
    chk("req_held", burst_req, 1);
    next_cyc();
    burst_ack = 1'b1;
    #4;
    next_cyc();
    burst_ack = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (drop_en && k == 5) enable = 1'b0;
      if (mode == 1) begin
        if (rcnt == 20 && !stalled) begin stall_left = 3; stalled = 1; end
        dst_ready = (k % 2 == 0);
        rempty = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        dst_ready = 1'b1;
        rempty = 1'b0;
      end
      #4;
      if (k == 0) chk("req_dropped_in_read", burst_req, 0);
      if (fifo_r_en && (!dst_ready || rempty)) viol++;
      if (mode == 0 && (fifo_r_en != (k < exp_len))) viol++;
      if (data_valid != prev_ren) viol++;
      prev_ren = fifo_r_en;
      if (fifo_r_en) rcnt++;
      if (data_valid) vcnt++;
      if (burst_last) begin lastcnt++; lastpos = vcnt; lastcyc = k; end
      if (burst_done) begin donecyc = k; break; end
      if (abort_at > 0 && rcnt == abort_at) return;
      next_cyc();
    end
    chk("read_count", rcnt, exp_len);
    chk("valid_count", vcnt, exp_len);
    chk("last_count", lastcnt, 1);
    chk("last_on_final_word", lastpos, exp_len);
    chk("done_after_last", donecyc, lastcyc + 1);
    chk("protocol_violations", viol, 0);
  endtask

  initial begin
    int w;
    bit [5:0] o;
    // Small bursts driven cycle by cycle.
    tbl.push_back(mk(1,0,0,0,0,0, 6'b000000, 0));  // idle, level 0
    tbl.push_back(mk(1,1,0,0,0,0, 6'b000000, 0));  // flush at level 0 is dropped
    tbl.push_back(mk(1,0,0,0,0,3, 6'b000000, 0));  // sub-burst level, no trigger
    tbl.push_back(mk(1,1,0,0,0,3, 6'b000000, 0));  // flush launches
    tbl.push_back(mk(1,0,0,0,0,3, 6'b010001, 3));  // REQ
    tbl.push_back(mk(1,0,1,0,0,3, 6'b010001, 3));  // REQ + ack
    tbl.push_back(mk(1,0,0,1,0,3, 6'b100001, 3));  // read word 0
    tbl.push_back(mk(1,1,0,0,0,3, 6'b001001, 3));  // not ready; flush latched while busy
    tbl.push_back(mk(1,0,0,1,1,3, 6'b000001, 3));  // empty stalls
    tbl.push_back(mk(1,0,0,1,0,3, 6'b100001, 3));  // word 1
    tbl.push_back(mk(1,0,0,1,0,3, 6'b101001, 3));  // word 2 (final)
    tbl.push_back(mk(1,0,0,1,0,3, 6'b001101, 3));  // DRAIN: last valid
    tbl.push_back(mk(1,0,0,1,0,3, 6'b000011, 3));  // burst_done
    tbl.push_back(mk(1,0,0,0,0,0, 6'b000000, 3));  // IDLE at level 0 drops latched flush
    tbl.push_back(mk(1,0,0,0,0,3, 6'b000000, 3));
    tbl.push_back(mk(1,0,0,0,0,3, 6'b000000, 3));
    tbl.push_back(mk(1,0,0,0,0,3, 6'b000000, 3));  // still no request
    tbl.push_back(mk(0,1,0,0,0,3, 6'b000000, 3));  // disabled: flush retained
    tbl.push_back(mk(0,0,0,0,0,3, 6'b000000, 3));
    tbl.push_back(mk(1,0,0,0,0,3, 6'b000000, 3));  // re-enable launches on retained flush
    tbl.push_back(mk(1,0,0,0,0,3, 6'b010001, 3));
    tbl.push_back(mk(1,0,1,0,0,3, 6'b010001, 3));
    tbl.push_back(mk(1,0,0,1,0,0, 6'b100001, 3));
    tbl.push_back(mk(1,0,0,1,0,0, 6'b101001, 3));
    tbl.push_back(mk(1,0,0,1,0,0, 6'b101001, 3));
    tbl.push_back(mk(1,0,0,1,0,0, 6'b001101, 3));
    tbl.push_back(mk(1,0,0,1,0,0, 6'b000011, 3));
    tbl.push_back(mk(1,0,0,0,0,0, 6'b000000, 3));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {fifo_r_en, burst_req, data_valid, burst_last, burst_done, busy}, 0);
    chk("reset_burst_len", burst_len, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      enable = tbl[i].en; flush = tbl[i].fl; burst_ack = tbl[i].ack;
      dst_ready = tbl[i].rdy; rempty = tbl[i].emp; level = LW'(tbl[i].lvl);
      #4;
      o = {fifo_r_en, burst_req, data_valid, burst_last, burst_done, busy};
      if (o != tbl[i].exp_o) $display("  (vector %0d)", i);
      chk("vec_outputs", o, tbl[i].exp_o);
      chk("vec_burst_len", burst_len, tbl[i].exp_len);
      next_cyc();
    end
    flush = 1'b0; burst_ack = 1'b0;

    // Full burst.
    level = LW'(64);
    run_burst(64, 0, 0, 0, w);
    chk("full_req_latency", w, 1);
    next_cyc();
    level = '0;
    next_cyc();

    // Timeout-forced partial burst.
    level = LW'(10);
    run_burst(10, 0, 0, 0, w);
    chk("timeout_req_latency", w, 1024);
    next_cyc();
    level = '0;
    next_cyc();

    // Toggling dst_ready with an empty stall at word 20.
    level = LW'(64);
    run_burst(64, 1, 0, 0, w);
    chk("stall_req_latency", w, 1);
    next_cyc();
    level = '0;
    next_cyc();

    // Asynchronous reset mid-burst, then a clean full burst.
    level = LW'(64);
    run_burst(64, 0, 30, 0, w);
    #1 rst_n = 1'b0;
    #1;
    chk("midburst_reset_outputs",
        {fifo_r_en, burst_req, data_valid, burst_last, burst_done, busy}, 0);
    chk("midburst_reset_len", burst_len, 0);
    next_cyc();
    rst_n = 1'b1;
    run_burst(64, 0, 0, 0, w);
    chk("post_reset_req_latency", w, 1);
    next_cyc();

    // Back-to-back at level 128, then a burst during which enable drops.
    level = LW'(128);
    run_burst(64, 0, 0, 0, w);
    next_cyc();
    run_burst(64, 0, 0, 0, w);
    chk("back_to_back_gap", w, 1);
    next_cyc();
    run_burst(64, 0, 0, 1, w);
    chk("third_req_latency", w, 1);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        next_cyc();
        #4;
        if (burst_req || busy) seen++;
      end
      chk("no_request_when_disabled", seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
